// File: rtl/passcode_entry_sequencer.sv
// passcode_entry_sequencer
// Operator front end for the 4-digit lock: conditions the raw ENTER and CLEAR
// buttons, latches one switch digit per accepted ENTER press, strobes it into
// the lock at the current position and waits for the lock's verdict after the
// fourth digit.
//
// Handshake with the lock: enteredPassword is valid and stable whenever any
// enable bit is high; enable is one-hot (bit = position) for STROBE_CYCLES
// cycles per digit and never carries two bits at once. The lock reports back
// through admitted, which is treated as already synchronous to clock.
module passcode_entry_sequencer #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int STROBE_CYCLES   = 2,
  parameter int TIMEOUT_CYCLES  = 40
) (
  input  logic       clock,
  input  logic       rst,
  input  logic [3:0] digit_in,
  input  logic       enter_btn,
  input  logic       clear_btn,
  input  logic       admitted,
  output logic [3:0] enteredPassword,
  output logic [3:0] enable,
  output logic [1:0] digit_pos,
  output logic       busy,
  output logic       timeout_flag
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int SW = $clog2(STROBE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

  typedef enum logic [1:0] {
    ST_WAIT   = 2'd0,
    ST_STROBE = 2'd1,
    ST_HOLD   = 2'd2,
    ST_DONE   = 2'd3
  } state_t;

  // Button index 0 is ENTER, index 1 is CLEAR.
  logic [1:0]    btn_raw;
  logic [1:0]    btn_sync_1;
  logic [1:0]    btn_sync_2;
  logic [1:0]    btn_level;
  logic [1:0]    btn_rise;
  logic [DW-1:0] btn_cnt [2];

  logic          admitted_q;
  logic          admit_fall;
  logic          enter_evt;
  logic          clear_evt;
  logic          enter_level;

  state_t        state;
  logic [SW-1:0] strobe_cnt;
  logic [TW-1:0] to_cnt;
  logic          done_mark;
  logic          seen_admit;

  assign btn_raw     = {clear_btn, enter_btn};
  assign enter_evt   = btn_rise[0];
  assign clear_evt   = btn_rise[1];
  assign enter_level = btn_level[0];
  assign admit_fall  = admitted_q & ~admitted;

  // Two-flop synchronizer for both asynchronous buttons.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      btn_sync_1 <= '0;
      btn_sync_2 <= '0;
    end else begin
      btn_sync_1 <= btn_raw;
      btn_sync_2 <= btn_sync_1;
    end
  end

  // Debounced level flips after DEBOUNCE_CYCLES disagreeing samples; a rise emits a one-cycle press event.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      btn_level <= '0;
      btn_rise  <= '0;
      for (int i = 0; i < 2; i++) btn_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < 2; i++) begin
        btn_rise[i] <= 1'b0;
        if (btn_sync_2[i] == btn_level[i]) begin
          btn_cnt[i] <= '0;
        end else if (btn_cnt[i] == DW'(DEBOUNCE_CYCLES - 1)) begin
          btn_level[i] <= btn_sync_2[i];
          btn_cnt[i]   <= '0;
          btn_rise[i]  <= btn_sync_2[i];
        end else begin
          btn_cnt[i] <= btn_cnt[i] + DW'(1);
        end
      end
    end
  end

  // One-flop history of admitted, used to spot the end of the lock's open period.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) admitted_q <= 1'b0;
    else      admitted_q <= admitted;
  end

  // Entry sequencer: WAIT for a press, STROBE the digit, HOLD until release, DONE until the lock answers.
  always_ff @(posedge clock or negedge rst) begin
    if (!rst) begin
      state           <= ST_WAIT;
      enteredPassword <= '0;
      enable          <= '0;
      digit_pos       <= '0;
      busy            <= 1'b0;
      timeout_flag    <= 1'b0;
      strobe_cnt      <= '0;
      to_cnt          <= '0;
      done_mark       <= 1'b0;
      seen_admit      <= 1'b0;
    end else begin
      timeout_flag <= 1'b0;
      if (clear_evt) begin
        // CLEAR outranks a same-cycle ENTER and any pending timeout.
        state           <= ST_WAIT;
        enteredPassword <= '0;
        enable          <= '0;
        digit_pos       <= '0;
        busy            <= 1'b0;
        strobe_cnt      <= '0;
        to_cnt          <= '0;
        done_mark       <= 1'b0;
        seen_admit      <= 1'b0;
      end else begin
        case (state)
          ST_WAIT: begin
            if (enter_evt) begin
              enteredPassword <= digit_in;
              enable          <= 4'b0001 << digit_pos;
              busy            <= 1'b1;
              strobe_cnt      <= '0;
              to_cnt          <= '0;
              state           <= ST_STROBE;
            end else if (digit_pos != 2'd0) begin
              if (to_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
                digit_pos       <= '0;
                enteredPassword <= '0;
                timeout_flag    <= 1'b1;
                to_cnt          <= '0;
              end else begin
                to_cnt <= to_cnt + TW'(1);
              end
            end else begin
              to_cnt <= '0;
            end
          end
          ST_STROBE: begin
            if (strobe_cnt == SW'(STROBE_CYCLES - 1)) begin
              enable     <= '0;
              digit_pos  <= digit_pos + 2'd1;
              done_mark  <= (digit_pos == 2'd3);
              strobe_cnt <= '0;
              state      <= ST_HOLD;
            end else begin
              strobe_cnt <= strobe_cnt + SW'(1);
            end
          end
          ST_HOLD: begin
            // Waiting for release keeps a held button from entering twice.
            if (!enter_level) begin
              to_cnt <= '0;
              if (done_mark) begin
                seen_admit <= 1'b0;
                state      <= ST_DONE;
              end else begin
                busy  <= 1'b0;
                state <= ST_WAIT;
              end
            end
          end
          ST_DONE: begin
            if (admitted) seen_admit <= 1'b1;
            if (admit_fall ||
                (!seen_admit && !admitted && to_cnt == TW'(TIMEOUT_CYCLES - 1))) begin
              timeout_flag    <= !admit_fall;
              enteredPassword <= '0;
              digit_pos       <= '0;
              busy            <= 1'b0;
              done_mark       <= 1'b0;
              seen_admit      <= 1'b0;
              to_cnt          <= '0;
              state           <= ST_WAIT;
            end else if (to_cnt != TW'(TIMEOUT_CYCLES)) begin
              to_cnt <= to_cnt + TW'(1);
            end
          end
          default: state <= ST_WAIT;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_passcode_entry_sequencer.sv
// Bench for passcode_entry_sequencer: directed timing scenarios plus a
// randomized entry/clear/admit sequence checked against a digit-position model.
module tb_passcode_entry_sequencer;

  localparam int STB     = 2;   // strobe width in cycles
  localparam int TMO     = 40;  // idle cycles before abandonment
  localparam int EVT_LAT = 6;   // raw press to press event: 2 sync + 4 debounce
  localparam int EN_LAT  = EVT_LAT + 1;  // enable registers one cycle after the event

  // ---------------- clock / reset ----------------
  logic       clock = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] digit_in = 4'd0;
  logic       enter_btn = 1'b0;
  logic       clear_btn = 1'b0;
  logic       admitted = 1'b0;
  logic [3:0] enteredPassword;
  logic [3:0] enable;
  logic [1:0] digit_pos;
  logic       busy;
  logic       timeout_flag;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  passcode_entry_sequencer dut (
    .clock           (clock),
    .rst             (rst),
    .digit_in        (digit_in),
    .enter_btn       (enter_btn),
    .clear_btn       (clear_btn),
    .admitted        (admitted),
    .enteredPassword (enteredPassword),
    .enable          (enable),
    .digit_pos       (digit_pos),
    .busy            (busy),
    .timeout_flag    (timeout_flag)
  );

  // ---------------- strobe monitor ----------------
  logic [5:0] obs_q[$];        // {position, digit} per observed strobe
  int         obs_width_q[$];
  int         obs_start_q[$];
  logic [3:0] mon_prev_en = 4'd0;
  logic [3:0] mon_digit = 4'd0;
  int         mon_start = 0;
  int         mon_width = 0;
  int         onehot_viol = 0;
  int         stable_viol = 0;
  int         to_pulses = 0;
  int         last_to_cyc = 0;

  function automatic logic [1:0] onehot_pos(input logic [3:0] e);
    onehot_pos = 2'd0;
    for (int k = 0; k < 4; k++) if (e[k]) onehot_pos = 2'(k);
  endfunction

  always @(negedge clock) begin
    if ($countones(enable) > 1) onehot_viol++;
    if (timeout_flag === 1'b1) begin
      to_pulses++;
      last_to_cyc = cyc;
    end
    if (enable != 4'd0 && mon_prev_en == 4'd0) begin
      mon_start = cyc;
      mon_width = 1;
      mon_digit = enteredPassword;
    end else if (enable != 4'd0) begin
      mon_width++;
      if (enteredPassword !== mon_digit || enable !== mon_prev_en) stable_viol++;
    end else if (mon_prev_en != 4'd0) begin
      obs_q.push_back({onehot_pos(mon_prev_en), mon_digit});
      obs_width_q.push_back(mon_width);
      obs_start_q.push_back(mon_start);
    end
    mon_prev_en = (enable === 4'bxxxx) ? 4'd0 : enable;
  end

  // ---------------- driver tasks ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic flush_obs();
    obs_q.delete();
    obs_width_q.delete();
    obs_start_q.delete();
    to_pulses = 0;
  endtask

  task automatic do_reset();
    rst = 1'b0; enter_btn = 1'b0; clear_btn = 1'b0; admitted = 1'b0; digit_in = 4'd0;
    tick(2);
    rst = 1'b1;
    tick(2);
    flush_obs();
  endtask

  // Clean ENTER press; rel is the cycle at which the button is let go.
  task automatic press(input logic [3:0] d, input int hold, input int gap, output int rel);
    digit_in = d;
    enter_btn = 1'b1;
    tick(hold);
    enter_btn = 1'b0;
    rel = cyc;
    tick(gap);
  endtask

  task automatic press_clear(input int hold, input int gap);
    clear_btn = 1'b1;
    tick(hold);
    clear_btn = 1'b0;
    tick(gap);
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    int t0;
    rst = 1'b0; enter_btn = 1'b1; digit_in = 4'd1;
    tick(3);
    checks++; if (enable !== 4'd0) begin errors++; $display("FAIL reset_enable: got %h want 0", enable); end
    checks++; if (enteredPassword !== 4'd0) begin errors++; $display("FAIL reset_password: got %h want 0", enteredPassword); end
    checks++; if (digit_pos !== 2'd0) begin errors++; $display("FAIL reset_pos: got %0d want 0", digit_pos); end
    checks++; if (busy !== 1'b0 || timeout_flag !== 1'b0) begin errors++; $display("FAIL reset_flags: got busy=%b to=%b want 0 0", busy, timeout_flag); end
    flush_obs();
    rst = 1'b1;
    t0 = cyc;
    tick(12);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL reset_stuck_enter_events: got %0d strobes want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_q[0] !== {2'd0, 4'd1}) begin errors++; $display("FAIL reset_first_strobe: got %h want %h", obs_q[0], {2'd0, 4'd1}); end
      checks++; if (obs_width_q[0] != STB) begin errors++; $display("FAIL reset_strobe_width: got %0d want %0d", obs_width_q[0], STB); end
      checks++; if (obs_start_q[0] != t0 + EN_LAT) begin errors++; $display("FAIL reset_strobe_latency: got %0d want %0d", obs_start_q[0] - t0, EN_LAT); end
    end
    checks++; if (busy !== 1'b1 || digit_pos !== 2'd1) begin errors++; $display("FAIL reset_hold: got busy=%b pos=%0d want 1 1", busy, digit_pos); end
    enter_btn = 1'b0;
    tick(10);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_release_busy: got %b want 0", busy); end
  endtask

  task automatic test_full_sequence();
    int rel;
    do_reset();
    for (int i = 0; i < 4; i++) begin
      press(4'(i + 1), $urandom_range(8, 14), $urandom_range(10, 16), rel);
      checks++; if (digit_pos !== 2'((i + 1) % 4)) begin errors++; $display("FAIL full_pos_%0d: got %0d want %0d", i, digit_pos, (i + 1) % 4); end
      checks++; if (enteredPassword !== 4'(i + 1)) begin errors++; $display("FAIL full_digit_%0d: got %0d want %0d", i, enteredPassword, i + 1); end
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL full_done_busy: got %b want 1", busy); end
    checks++; if (obs_q.size() != 4) begin errors++; $display("FAIL full_strobe_count: got %0d want 4", obs_q.size()); end
    for (int i = 0; i < 4 && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== {2'(i), 4'(i + 1)}) begin errors++; $display("FAIL full_strobe_%0d: got %h want %h", i, obs_q[i], {2'(i), 4'(i + 1)}); end
      checks++; if (obs_width_q[i] != STB) begin errors++; $display("FAIL full_width_%0d: got %0d want %0d", i, obs_width_q[i], STB); end
    end
    admitted = 1'b1;
    tick(10);
    admitted = 1'b0;
    tick(2);
    checks++; if (busy !== 1'b0 || digit_pos !== 2'd0 || enteredPassword !== 4'd0) begin errors++; $display("FAIL full_admit_exit: got busy=%b pos=%0d pw=%0d want 0 0 0", busy, digit_pos, enteredPassword); end
    checks++; if (to_pulses != 0) begin errors++; $display("FAIL full_no_timeout: got %0d pulses want 0", to_pulses); end
  endtask

  task automatic test_bounce();
    int t0;
    do_reset();
    digit_in = 4'd7;
    for (int i = 0; i < 10; i++) begin
      enter_btn = (i % 2 == 0);
      tick(1);
    end
    enter_btn = 1'b1;
    t0 = cyc;
    tick(50);
    enter_btn = 1'b0;
    tick(12);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL bounce_single_event: got %0d strobes want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_start_q[0] != t0 + EN_LAT) begin errors++; $display("FAIL bounce_latency: got %0d want %0d", obs_start_q[0] - t0, EN_LAT); end
      checks++; if (obs_q[0] !== {2'd0, 4'd7} || obs_width_q[0] != STB) begin errors++; $display("FAIL bounce_strobe: got %h/%0d want %h/%0d", obs_q[0], obs_width_q[0], {2'd0, 4'd7}, STB); end
    end
  endtask

  task automatic test_timeout();
    int rel;
    do_reset();
    press(4'd5, 8, 10, rel);
    press(4'd9, 8, 10, rel);
    tick(28);
    checks++; if (digit_pos !== 2'd2 || to_pulses != 0) begin errors++; $display("FAIL timeout_early: got pos=%0d pulses=%0d want 2 0", digit_pos, to_pulses); end
    tick(22);
    checks++; if (to_pulses != 1) begin errors++; $display("FAIL timeout_pulse_count: got %0d want 1", to_pulses); end
    checks++; if (last_to_cyc < rel + TMO || last_to_cyc > rel + TMO + 10) begin errors++; $display("FAIL timeout_when: got %0d after release want %0d..%0d", last_to_cyc - rel, TMO, TMO + 10); end
    checks++; if (digit_pos !== 2'd0 || enteredPassword !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL timeout_state: got pos=%0d pw=%0d busy=%b want 0 0 0", digit_pos, enteredPassword, busy); end
    // Completed entry that the lock never answers.
    do_reset();
    for (int i = 0; i < 4; i++) press(4'(i + 3), 8, 10, rel);
    tick(25);
    checks++; if (busy !== 1'b1 || to_pulses != 0) begin errors++; $display("FAIL done_timeout_early: got busy=%b pulses=%0d want 1 0", busy, to_pulses); end
    tick(25);
    checks++; if (to_pulses != 1 || busy !== 1'b0 || enteredPassword !== 4'd0 || digit_pos !== 2'd0) begin errors++; $display("FAIL done_timeout: got pulses=%0d busy=%b pw=%0d pos=%0d want 1 0 0 0", to_pulses, busy, enteredPassword, digit_pos); end
    // An admitted seen in DONE suppresses the timeout exit.
    do_reset();
    for (int i = 0; i < 4; i++) press(4'(i + 8), 8, 10, rel);
    admitted = 1'b1;
    tick(50);
    checks++; if (busy !== 1'b1 || to_pulses != 0) begin errors++; $display("FAIL admit_hold_busy: got busy=%b pulses=%0d want 1 0", busy, to_pulses); end
    admitted = 1'b0;
    tick(3);
    checks++; if (busy !== 1'b0 || to_pulses != 0) begin errors++; $display("FAIL admit_fall_exit: got busy=%b pulses=%0d want 0 0", busy, to_pulses); end
  endtask

  task automatic test_clear_priority();
    int rel;
    int t0;
    do_reset();
    press(4'd5, 8, 10, rel);
    press(4'd6, 8, 10, rel);
    flush_obs();
    digit_in = 4'd9;
    clear_btn = 1'b1;
    enter_btn = 1'b1;
    tick(12);
    clear_btn = 1'b0;
    enter_btn = 1'b0;
    tick(12);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL clear_enter_no_strobe: got %0d strobes want 0", obs_q.size()); end
    checks++; if (digit_pos !== 2'd0 || enteredPassword !== 4'd0 || busy !== 1'b0) begin errors++; $display("FAIL clear_enter_state: got pos=%0d pw=%0d busy=%b want 0 0 0", digit_pos, enteredPassword, busy); end
    // CLEAR arriving one cycle behind ENTER lands on the first strobe cycle.
    flush_obs();
    digit_in = 4'd5;
    enter_btn = 1'b1;
    t0 = cyc;
    tick(1);
    clear_btn = 1'b1;
    tick(12);
    enter_btn = 1'b0;
    clear_btn = 1'b0;
    tick(12);
    checks++; if (obs_q.size() != 1) begin errors++; $display("FAIL clear_strobe_count: got %0d want 1", obs_q.size()); end
    if (obs_q.size() >= 1) begin
      checks++; if (obs_width_q[0] != 1 || obs_start_q[0] != t0 + EN_LAT) begin errors++; $display("FAIL clear_truncate: got width=%0d start=%0d want 1 %0d", obs_width_q[0], obs_start_q[0] - t0, EN_LAT); end
    end
    checks++; if (digit_pos !== 2'd0 || enteredPassword !== 4'd0) begin errors++; $display("FAIL clear_strobe_state: got pos=%0d pw=%0d want 0 0", digit_pos, enteredPassword); end
  endtask

  task automatic test_random();
    int pos;
    bit done;
    int rel;
    logic [3:0] d;
    logic [5:0] exp_q[$];
    do_reset();
    pos = 0;
    done = 0;
    for (int i = 0; i < 30; i++) begin
      if (done) begin
        if ($urandom_range(0, 1) == 1) begin
          admitted = 1'b1;
          tick($urandom_range(1, 10));
          admitted = 1'b0;
          tick(3);
        end else begin
          press_clear($urandom_range(6, 12), 10);
        end
        pos = 0;
        done = 0;
      end else if ($urandom_range(0, 5) == 0) begin
        press_clear($urandom_range(6, 12), 10);
        pos = 0;
      end else begin
        d = 4'($urandom_range(0, 15));
        press(d, $urandom_range(6, 16), $urandom_range(10, 20), rel);
        exp_q.push_back({2'(pos), d});
        pos = (pos + 1) % 4;
        if (pos == 0) done = 1;
      end
      checks++; if (digit_pos !== 2'(pos)) begin errors++; $display("FAIL rand_pos_%0d: got %0d want %0d", i, digit_pos, pos); end
      checks++; if (busy !== logic'(done)) begin errors++; $display("FAIL rand_busy_%0d: got %b want %b", i, busy, done); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL rand_strobe_count: got %0d want %0d", obs_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
      checks++; if (obs_q[i] !== exp_q[i] || obs_width_q[i] != STB) begin errors++; $display("FAIL rand_strobe_%0d: got %h/%0d want %h/%0d", i, obs_q[i], obs_width_q[i], exp_q[i], STB); end
    end
    checks++; if (to_pulses != 0) begin errors++; $display("FAIL rand_no_timeout: got %0d pulses want 0", to_pulses); end
  endtask

  task automatic test_mid_reset();
    int rel;
    int waited;
    do_reset();
    press(4'd3, 8, 12, rel);
    press(4'd6, 8, 12, rel);
    digit_in = 4'd9;
    enter_btn = 1'b1;
    waited = 0;
    while (enable === 4'd0 && waited < 20) begin
      tick(1);
      waited++;
    end
    checks++; if (enable !== 4'b0100) begin errors++; $display("FAIL mid_reset_third_strobe: got %b want 0100", enable); end
    #2 rst = 1'b0;
    #1;
    checks++; if (enable !== 4'd0 || enteredPassword !== 4'd0 || digit_pos !== 2'd0 || busy !== 1'b0) begin errors++; $display("FAIL mid_reset_async: got en=%b pw=%0d pos=%0d busy=%b want 0 0 0 0", enable, enteredPassword, digit_pos, busy); end
    enter_btn = 1'b0;
    tick(3);
    flush_obs();
    rst = 1'b1;
    tick(15);
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_reset_no_resume: got %0d strobes want 0", obs_q.size()); end
    press(4'd11, 8, 12, rel);
    checks++; if (obs_q.size() != 1 || obs_q[0] !== {2'd0, 4'd11}) begin errors++; $display("FAIL mid_reset_next_press: got %0d strobes first %h want 1 %h", obs_q.size(), (obs_q.size() > 0) ? obs_q[0] : 6'd0, {2'd0, 4'd11}); end
  endtask

  task automatic test_invariants();
    checks++; if (onehot_viol != 0) begin errors++; $display("FAIL enable_onehot: got %0d multi-bit cycles want 0", onehot_viol); end
    checks++; if (stable_viol != 0) begin errors++; $display("FAIL strobe_stability: got %0d unstable cycles want 0", stable_viol); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_full_sequence();
    test_bounce();
    test_timeout();
    test_clear_priority();
    test_random();
    test_mid_reset();
    test_invariants();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation still running at %0t", $time);
    $fatal(1, "watchdog expired");
  end

endmodule
